// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NUM_REQ
// writeback sources, with one registered output stage driving the port.
module wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0] req_waddr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   input  logic                      stall_i,
   output logic [ADDR_W-1:0]         reg_waddr_o,
   output logic [DATA_W-1:0]         reg_wdata_o,
   output logic                      reg_wen_o,
   output logic                      busy_o
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CW    = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [ADDR_W-1:0] waddr_arr [NUM_REQ];
   logic [DATA_W-1:0] wdata_arr [NUM_REQ];

   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic [PTR_W-1:0]  rr_ptr;

   logic              can_accept;
   logic              drained;
   logic              gnt_hit;
   logic [PTR_W-1:0]  gnt_idx;
   logic              grant;
   logic              load;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign waddr_arr[k] = req_waddr_i[k*ADDR_W +: ADDR_W];
      assign wdata_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
   end

   assign drained    = out_valid & ~stall_i;
   assign can_accept = ~out_valid | ~stall_i;

   // Search starts at rr_ptr and wraps; the first valid index wins.
   always_comb begin
      logic [CW-1:0] cand;
      // NOTE: every variable gets a default first so no path infers a latch.
      cand    = '0;
      gnt_hit = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + CW'(i);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!gnt_hit && req_valid_i[cand[PTR_W-1:0]]) begin
            gnt_hit = 1'b1;
            gnt_idx = cand[PTR_W-1:0];
         end
      end
   end

   // Ready is forced low while reset is asserted, even with valids pending.
   assign grant       = gnt_hit & can_accept & ~rst_i;
   assign req_ready_o = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign load        = grant & (waddr_arr[gnt_idx] != '0);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else begin
         // x0 grants complete the handshake but never load the stage.
         if (load) begin
            out_valid <= 1'b1;
            out_addr  <= waddr_arr[gnt_idx];
            out_data  <= wdata_arr[gnt_idx];
         end else if (drained) begin
            out_valid <= 1'b0;
         end
         if (grant) begin
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
         end
      end
   end

   assign reg_waddr_o = out_addr;
   assign reg_wdata_o = out_data;
   assign reg_wen_o   = out_valid & ~stall_i;
   assign busy_o      = out_valid;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-requester transaction queues drive the
// ports, a queue-based reference model predicts grants and regfile writes.
module tb_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } item_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [N-1:0]  req_valid_i = '0;
   logic [N-1:0]  req_ready_o;
   logic [N*AW-1:0] req_waddr_i = '0;
   logic [N*DW-1:0] req_wdata_i = '0;
   logic          stall_i = 1'b0;
   logic [AW-1:0] reg_waddr_o;
   logic [DW-1:0] reg_wdata_o;
   logic          reg_wen_o;
   logic          busy_o;

   wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_waddr_i (req_waddr_i),
      .req_wdata_i (req_wdata_i),
      .stall_i     (stall_i),
      .reg_waddr_o (reg_waddr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_wen_o   (reg_wen_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   item_t src_q [N][$];   // pending transactions per requester
   item_t exp_q [$];      // entries expected to reach the regfile, in order
   int    rr_model = 0;
   logic [N-1:0]  hs = '0;
   logic [N-1:0]  prev_valid = '0;
   logic [N-1:0]  prev_hs = '0;
   logic [AW-1:0] prev_addr [N];
   logic [DW-1:0] prev_data [N];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      item_t it;
      it.addr = a;
      it.data = d;
      src_q[k].push_back(it);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   function automatic int pending();
      int p;
      p = exp_q.size();
      for (int k = 0; k < N; k++) p += src_q[k].size();
      return p;
   endfunction

   // Driver: present the head of each requester queue, retire it on handshake.
   always @(posedge clk_i) begin
      #1;
      for (int k = 0; k < N; k++) begin
         if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
         if (src_q[k].size() > 0) begin
            req_valid_i[k]            = 1'b1;
            req_waddr_i[k*AW +: AW]   = src_q[k][0].addr;
            req_wdata_i[k*DW +: DW]   = src_q[k][0].data;
         end else begin
            req_valid_i[k] = 1'b0;
         end
      end
      hs = '0;
   end

   // Monitor and reference model, sampled mid-cycle.
   int    exp_gnt;
   logic  exp_busy;
   logic  can_acc;
   logic [N-1:0] exp_ready;
   item_t got;

   always @(negedge clk_i) begin
      if (rst_i) begin
         exp_q.delete();
         rr_model   = 0;
         hs         = '0;
         prev_valid = '0;
         prev_hs    = '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (prev_valid[k] && !prev_hs[k]) begin
               check("req_hold_valid", req_valid_i[k], 1'b1);
               check("req_hold_addr", req_waddr_i[k*AW +: AW], prev_addr[k]);
               check("req_hold_data", req_wdata_i[k*DW +: DW], prev_data[k]);
            end
         end

         exp_busy = (exp_q.size() != 0);
         can_acc  = !exp_busy || !stall_i;
         exp_gnt  = -1;
         if (can_acc) begin
            for (int i = 0; i < N; i++) begin
               if (exp_gnt < 0 && req_valid_i[(rr_model + i) % N]) exp_gnt = (rr_model + i) % N;
            end
         end
         exp_ready = (exp_gnt >= 0) ? N'(1) << exp_gnt : '0;

         check("ready", req_ready_o, exp_ready);
         check("busy", busy_o, exp_busy);
         check("wen", reg_wen_o, exp_busy && !stall_i);
         if (exp_busy) begin
            check("out_addr", reg_waddr_o, exp_q[0].addr);
            check("out_data", reg_wdata_o, exp_q[0].data);
            if (!stall_i) void'(exp_q.pop_front());
         end

         if (exp_gnt >= 0) begin
            rr_model = (exp_gnt + 1) % N;
            got.addr = req_waddr_i[exp_gnt*AW +: AW];
            got.data = req_wdata_i[exp_gnt*DW +: DW];
            if (got.addr != '0) exp_q.push_back(got);
         end

         hs         = req_valid_i & req_ready_o;
         prev_valid = req_valid_i;
         prev_hs    = hs;
         for (int k = 0; k < N; k++) begin
            prev_addr[k] = req_waddr_i[k*AW +: AW];
            prev_data[k] = req_wdata_i[k*DW +: DW];
         end
      end
   end

   initial begin
      // Reset with a request already pending: ready must stay low.
      push(0, 5'd3, 32'h0000_0003);
      step(1);
      check("rst_ready", req_ready_o, '0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_wen", reg_wen_o, 1'b0);
      step(1);
      rst_i = 1'b0;
      step(6);

      // Single requester, then steer rr_ptr back to 0 via req2.
      push(1, 5'd5, 32'hDEAD_BEEF);
      step(6);
      push(2, 5'd6, 32'h0000_0606);
      step(6);

      // All three valid back-to-back from rr_ptr=0.
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < N; k++) push(k, AW'(8 + 4*j + k), 32'hA000_0000 + DW'(16*j + k));
      end
      step(12);

      // x0 write from req0: handshake only, rr_ptr moves to 1.
      push(0, 5'd0, 32'h0000_ABCD);
      step(6);

      // Wrap and skip: reach rr_ptr=2, req1 alone, then req0+req2.
      push(1, 5'd17, 32'h1111_0001);
      step(5);
      push(1, 5'd18, 32'h1111_0002);
      step(5);
      push(0, 5'd19, 32'h0000_0019);
      push(2, 5'd20, 32'h2222_0020);
      step(8);

      // Stall with an entry held and req2 waiting.
      stall_i = 1'b1;
      push(0, 5'd21, 32'h5757_0021);
      step(2);
      push(2, 5'd22, 32'h5757_0022);
      step(3);
      stall_i = 1'b0;
      step(6);

      // Asynchronous reset mid-cycle while an entry is held.
      stall_i = 1'b1;
      push(1, 5'd9, 32'h1234_5678);
      step(3);
      check("pre_rst_busy", busy_o, 1'b1);
      rst_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 1'b0);
      check("arst_wen", reg_wen_o, 1'b0);
      check("arst_addr", reg_waddr_o, '0);
      check("arst_data", reg_wdata_o, '0);
      check("arst_ready", req_ready_o, '0);
      step(2);
      rst_i   = 1'b0;
      stall_i = 1'b0;
      for (int k = 0; k < N; k++) push(k, AW'(24 + k), 32'hC0DE_0000 + DW'(k));
      step(8);

      // Randomized traffic with random stalls and occasional x0 writes.
      for (int c = 0; c < 2000; c++) begin
         step(1);
         for (int k = 0; k < N; k++) begin
            if (src_q[k].size() < 2 && $urandom_range(0, 2) == 0)
               push(k, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)), DW'($urandom));
         end
         stall_i = ($urandom_range(0, 3) == 0);
      end

      stall_i = 1'b0;
      for (int w = 0; w < 200 && pending() > 0; w++) step(1);
      step(2);
      check("drain_pending", pending(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
